kanagawa_ram_ecc_scrubber: RTL and testbench

- Sits directly upstream of the dual-port RAM HAL in simple mode: port 0 is write, port 1 is read.
- Muxes user read/write traffic with a background scrub engine onto the RAM ports.
- The scrub engine walks every address, reads it, and writes back ECC-corrected data when a correctable error is reported.
- Counts corrected and uncorrectable events, and flags user reads that returned bad data.

---
 rtl/kanagawa_scrub_pkg.sv | 18 +
 rtl/kanagawa_scrub_tag_pipe.sv | 27 ++
 rtl/kanagawa_ram_ecc_scrubber.sv | 140 ++++++++++++++
 tb/tb_kanagawa_ram_ecc_scrubber.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kanagawa_scrub_pkg.sv
// kanagawa_scrub_pkg: shared types and helpers for the RAM ECC scrubber.
package kanagawa_scrub_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITEBACK} scrub_state_t;

    typedef struct packed {
        logic valid;
        logic is_scrub;
    } read_tag_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_v) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/kanagawa_scrub_tag_pipe.sv
// kanagawa_scrub_tag_pipe: READ_LATENCY-deep shift register tagging each port-1 read
// so returning data can be routed to the user or to the scrub engine.
module kanagawa_scrub_tag_pipe
    import kanagawa_scrub_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  read_tag_t i_tag,
    output read_tag_t o_tag
);

    read_tag_t r_pipe [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_tag = r_pipe[READ_LATENCY-1];

endmodule

// File: rtl/kanagawa_ram_ecc_scrubber.sv
// kanagawa_ram_ecc_scrubber: muxes user traffic with a background scrub engine that reads
// every RAM word, writes back ECC-corrected data and counts corrected/uncorrectable events.
module kanagawa_ram_ecc_scrubber
    import kanagawa_scrub_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int DEPTH          = 2**ADDR_WIDTH,
    parameter int READ_LATENCY   = 2,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             usr_wren_in,
    input  logic [ADDR_WIDTH-1:0]            usr_waddr_in,
    input  logic [DATA_WIDTH-1:0]            usr_wdata_in,
    input  logic                             usr_rden_in,
    input  logic [ADDR_WIDTH-1:0]            usr_raddr_in,
    output logic [DATA_WIDTH-1:0]            usr_rdata_out,
    output logic                             usr_rdata_valid_out,
    output logic                             usr_rdata_err_out,
    output logic [1:0][ADDR_WIDTH-1:0]       ram_addr_out,
    output logic [1:0]                       ram_wren_out,
    output logic [1:0][DATA_WIDTH-1:0]       ram_data_out,
    output logic [1:0]                       ram_rden_out,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_in,
    input  logic                             ram_error_detected_in,
    input  logic                             ram_data_valid_in,
    output logic [CNT_WIDTH-1:0]             corrected_cnt_out,
    output logic [CNT_WIDTH-1:0]             uncorrectable_cnt_out,
    output logic [ADDR_WIDTH-1:0]            last_bad_addr_out,
    output logic                             pass_done_out
);

    localparam int IW = $clog2(SCRUB_INTERVAL) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    scrub_state_t          r_state;
    logic [IW-1:0]         r_interval;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_cancel;
    logic [DATA_WIDTH-1:0] r_fix_data;
    logic [CNT_WIDTH-1:0]  r_corr_cnt;
    logic [CNT_WIDTH-1:0]  r_unc_cnt;
    logic [ADDR_WIDTH-1:0] r_last_bad;
    logic                  r_pass_done;

    read_tag_t w_tag_in;
    read_tag_t w_tag_out;
    logic      w_scrub_rd;
    logic      w_scrub_wr;
    logic      w_hit;
    logic      w_scrub_ret;
    logic      w_advance;

    assign w_scrub_rd  = (r_state == ISSUE) && !usr_rden_in;
    assign w_scrub_wr  = (r_state == WRITEBACK) && !r_cancel && !usr_wren_in;
    assign w_hit       = usr_wren_in && (usr_waddr_in == r_addr);
    assign w_scrub_ret = w_tag_out.valid && w_tag_out.is_scrub;
    assign w_tag_in    = '{valid: usr_rden_in || w_scrub_rd, is_scrub: w_scrub_rd};
    assign w_advance   = ((r_state == WAIT) && w_scrub_ret && !(ram_error_detected_in && ram_data_valid_in))
                      || ((r_state == WRITEBACK) && (r_cancel || !usr_wren_in));

    kanagawa_scrub_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Write enable is forced low during reset so initialised RAM contents survive.
    assign ram_addr_out[0] = usr_wren_in ? usr_waddr_in : r_addr;
    assign ram_addr_out[1] = usr_rden_in ? usr_raddr_in : r_addr;
    assign ram_wren_out    = {1'b0, !rst && (usr_wren_in || w_scrub_wr)};
    assign ram_data_out[0] = usr_wren_in ? usr_wdata_in : r_fix_data;
    assign ram_data_out[1] = '1;
    assign ram_rden_out    = {w_tag_in.valid, 1'b0};

    assign usr_rdata_out         = ram_rdata_in;
    assign usr_rdata_valid_out   = w_tag_out.valid && !w_tag_out.is_scrub;
    assign usr_rdata_err_out     = usr_rdata_valid_out && ram_error_detected_in && !ram_data_valid_in;
    assign corrected_cnt_out     = r_corr_cnt;
    assign uncorrectable_cnt_out = r_unc_cnt;
    assign last_bad_addr_out     = r_last_bad;
    assign pass_done_out         = r_pass_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_interval  <= IW'(SCRUB_INTERVAL - 1);
            r_addr      <= '0;
            r_cancel    <= 1'b0;
            r_fix_data  <= '0;
            r_corr_cnt  <= '0;
            r_unc_cnt   <= '0;
            r_last_bad  <= '0;
            r_pass_done <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_interval == '0) r_state <= ISSUE;
                    else r_interval <= r_interval - 1'b1;
                end
                ISSUE: begin
                    if (!usr_rden_in) begin
                        r_state  <= WAIT;
                        r_cancel <= w_hit;
                    end
                end
                WAIT: begin
                    r_cancel <= r_cancel || w_hit;
                    if (w_scrub_ret && ram_error_detected_in) begin
                        if (ram_data_valid_in) begin
                            r_corr_cnt <= CNT_WIDTH'(sat_inc(64'(r_corr_cnt), CNT_WIDTH));
                            r_fix_data <= ram_rdata_in;
                            r_state    <= WRITEBACK;
                        end else begin
                            r_unc_cnt  <= CNT_WIDTH'(sat_inc(64'(r_unc_cnt), CNT_WIDTH));
                            r_last_bad <= r_addr;
                        end
                    end
                end
                WRITEBACK: r_cancel <= r_cancel || w_hit;
                default: r_state <= IDLE;
            endcase
            // Finishing a word: step to the next address and restart the idle gap.
            if (w_advance) begin
                r_state     <= IDLE;
                r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_pass_done <= (r_addr == LAST_ADDR);
                r_interval  <= IW'(SCRUB_INTERVAL - 1);
            end
        end
    end

endmodule

// File: tb/tb_kanagawa_ram_ecc_scrubber.sv
// tb_kanagawa_ram_ecc_scrubber: directed/random checks of the scrubber against a RAM model
// with ECC fault injection and a reference array of expected RAM contents.
module tb_kanagawa_ram_ecc_scrubber;

    localparam int DW = 32, AW = 3, DEPTH = 8, RL = 2, SI = 4, CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic usr_wren_in = 1'b0;
    logic [AW-1:0] usr_waddr_in = '0;
    logic [DW-1:0] usr_wdata_in = '0;
    logic usr_rden_in = 1'b0;
    logic [AW-1:0] usr_raddr_in = '0;
    logic [DW-1:0] usr_rdata_out;
    logic usr_rdata_valid_out, usr_rdata_err_out;
    logic [1:0][AW-1:0] ram_addr_out;
    logic [1:0] ram_wren_out;
    logic [1:0][DW-1:0] ram_data_out;
    logic [1:0] ram_rden_out;
    logic [DW-1:0] ram_rdata_in = '0;
    logic ram_error_detected_in = 1'b0, ram_data_valid_in = 1'b0;
    logic [CW-1:0] corrected_cnt_out, uncorrectable_cnt_out;
    logic [AW-1:0] last_bad_addr_out;
    logic pass_done_out;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    kanagawa_ram_ecc_scrubber #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL),
        .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .usr_wren_in(usr_wren_in), .usr_waddr_in(usr_waddr_in), .usr_wdata_in(usr_wdata_in),
        .usr_rden_in(usr_rden_in), .usr_raddr_in(usr_raddr_in),
        .usr_rdata_out(usr_rdata_out), .usr_rdata_valid_out(usr_rdata_valid_out),
        .usr_rdata_err_out(usr_rdata_err_out),
        .ram_addr_out(ram_addr_out), .ram_wren_out(ram_wren_out), .ram_data_out(ram_data_out),
        .ram_rden_out(ram_rden_out), .ram_rdata_in(ram_rdata_in),
        .ram_error_detected_in(ram_error_detected_in), .ram_data_valid_in(ram_data_valid_in),
        .corrected_cnt_out(corrected_cnt_out), .uncorrectable_cnt_out(uncorrectable_cnt_out),
        .last_bad_addr_out(last_bad_addr_out), .pass_done_out(pass_done_out)
    );

    // RAM with 2-cycle read latency; kind 0 clean, 1 correctable, 2 uncorrectable.
    logic [DW-1:0] mem [DEPTH];
    logic [1:0] kind [DEPTH];
    logic ld_en = 1'b0, inj_en = 1'b0, inj_all = 1'b0;
    logic [AW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_d = '0;
    logic [1:0] cmd_k = '0;
    logic rd_q = 1'b0;
    logic [AW-1:0] ra_q = '0;

    always @(posedge clk) begin
        if (inj_all) for (int i = 0; i < DEPTH; i++) kind[i] <= cmd_k;
        if (inj_en) kind[cmd_a] <= cmd_k;
        if (ld_en) begin
            mem[cmd_a] <= cmd_d;
            kind[cmd_a] <= 2'd0;
        end
        if (ram_wren_out[0]) begin
            mem[ram_addr_out[0]] <= ram_data_out[0];
            kind[ram_addr_out[0]] <= 2'd0;
        end
        rd_q <= ram_rden_out[1];
        ra_q <= ram_addr_out[1];
        ram_rdata_in <= (kind[ra_q] == 2'd2) ? ~mem[ra_q] : mem[ra_q];
        ram_error_detected_in <= rd_q && (kind[ra_q] != 2'd0);
        ram_data_valid_in <= rd_q && (kind[ra_q] != 2'd2);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_a[$], rd_c[$], wr_a[$], wr_c[$];
    logic [DW-1:0] wr_d[$];
    int pass_n = 0, rst_wr = 0;

    always begin
        @(negedge clk);
        #1;
        if (ram_rden_out[1] && !usr_rden_in) begin
            rd_a.push_back(int'(ram_addr_out[1]));
            rd_c.push_back(cyc);
        end
        if (ram_wren_out[0] && !usr_wren_in) begin
            wr_a.push_back(int'(ram_addr_out[0]));
            wr_d.push_back(ram_data_out[0]);
            wr_c.push_back(cyc);
        end
        if (pass_done_out) pass_n++;
        if (rst && ram_wren_out !== 2'b00) rst_wr++;
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_d [100];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic exp_e, input string tag);
        @(negedge clk);
        usr_rden_in = 1'b1;
        usr_raddr_in = a;
        @(negedge clk);
        usr_rden_in = 1'b0;
        check({tag, "_early"}, 64'(usr_rdata_valid_out), 64'(0));
        @(negedge clk);
        check({tag, "_valid"}, 64'(usr_rdata_valid_out), 64'(1));
        check({tag, "_err"}, 64'(usr_rdata_err_out), 64'(exp_e));
        if (!exp_e) check({tag, "_data"}, 64'(usr_rdata_out), 64'(ref_mem[a]));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        usr_wren_in = 1'b1;
        usr_waddr_in = a;
        usr_wdata_in = d;
        ref_mem[a] = d;
        @(negedge clk);
        usr_wren_in = 1'b0;
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [1:0] k);
        @(negedge clk);
        inj_en = 1'b1;
        cmd_a = a;
        cmd_k = k;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    initial begin
        int n, t, wn, r3;
        // Reset with a user write strobe held high: the RAM must see no write.
        usr_wren_in = 1'b1;
        usr_waddr_in = 3'd3;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_en = 1'b1;
            cmd_a = AW'(i);
            cmd_d = $urandom;
            ref_mem[i] = cmd_d;
        end
        @(negedge clk);
        ld_en = 1'b0;
        check("rst_wren", 64'(ram_wren_out), 64'(0));
        check("rst_corr", 64'(corrected_cnt_out), 64'(0));
        check("rst_unc", 64'(uncorrectable_cnt_out), 64'(0));
        check("rst_bad", 64'(last_bad_addr_out), 64'(0));
        check("rst_valid", 64'(usr_rdata_valid_out), 64'(0));
        check("rst_err", 64'(usr_rdata_err_out), 64'(0));
        check("rst_pass", 64'(pass_done_out), 64'(0));
        usr_wren_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Clean pass over all addresses.
        t = 0;
        while (pass_n < 1 && t < 200) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check("pass_once", 64'(pass_n), 64'(1));
        check("pass_reads", 64'(rd_a.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < rd_a.size(); i++) check("pass_addr", 64'(rd_a[i]), 64'(i));
        for (int i = 1; i < rd_c.size(); i++) check("pass_space", 64'(rd_c[i] - rd_c[i-1]), 64'(SI + RL + 1));
        check("pass_nowr", 64'(wr_a.size()), 64'(0));
        check("pass_corr", 64'(corrected_cnt_out), 64'(0));
        check("pass_unc", 64'(uncorrectable_cnt_out), 64'(0));
        check("rden0_zero", 64'(ram_rden_out[0]), 64'(0));
        check("wren1_zero", 64'(ram_wren_out[1]), 64'(0));
        check("wdata1_ones", 64'(ram_data_out[1]), 64'(32'hFFFF_FFFF));

        // Correctable at 3, uncorrectable at 5.
        inject(3'd3, 2'd1);
        inject(3'd5, 2'd2);
        t = 0;
        while (corrected_cnt_out < 1 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("corr_cnt", 64'(corrected_cnt_out), 64'(1));
        check("corr_wr_n", 64'(wr_a.size()), 64'(1));
        r3 = -1;
        foreach (rd_a[i]) if (rd_a[i] == 3) r3 = rd_c[i];
        if (wr_a.size() >= 1) begin
            check("corr_wr_addr", 64'(wr_a[0]), 64'(3));
            check("corr_wr_data", 64'(wr_d[0]), 64'(ref_mem[3]));
            check("corr_wr_time", 64'(wr_c[0] - r3), 64'(RL + 1));
        end
        do_read(3'd3, 1'b0, "rd3");

        t = 0;
        while (uncorrectable_cnt_out < 1 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("unc_cnt", 64'(uncorrectable_cnt_out), 64'(1));
        check("unc_addr", 64'(last_bad_addr_out), 64'(5));
        check("unc_nowr", 64'(wr_a.size()), 64'(1));
        do_read(3'd5, 1'b1, "rd5_bad");
        do_write(3'd5, $urandom);
        do_read(3'd5, 1'b0, "rd5_new");

        // Correctable at 2, overwritten by the user while the scrub read is in flight.
        inject(3'd2, 2'd1);
        n = rd_a.size();
        t = 0;
        while (!(rd_a.size() > n && rd_a[rd_a.size()-1] == 2) && t < 200) begin @(negedge clk); t++; end
        check("canc_seen", 64'(rd_a.size() > n && rd_a[rd_a.size()-1] == 2), 64'(1));
        wn = wr_a.size();
        do_write(3'd2, 32'h0000_DEAD);
        repeat (6) @(negedge clk);
        check("canc_corr", 64'(corrected_cnt_out), 64'(2));
        check("canc_nowr", 64'(wr_a.size()), 64'(wn));
        do_read(3'd2, 1'b0, "rd2_dead");

        // Back-to-back random user reads (and writes) starve the scrub.
        for (int i = 0; i < 102; i++) begin
            @(negedge clk);
            if (i == 0) n = rd_a.size();
            if (i >= 2) begin
                check("burst_valid", 64'(usr_rdata_valid_out), 64'(1));
                check("burst_data", 64'(usr_rdata_out), 64'(exp_d[i-2]));
                check("burst_err", 64'(usr_rdata_err_out), 64'(0));
            end
            if (i < 100) begin
                usr_rden_in = 1'b1;
                usr_raddr_in = AW'($urandom_range(0, DEPTH - 1));
                usr_wren_in = 1'($urandom_range(0, 1));
                usr_waddr_in = AW'($urandom_range(0, DEPTH - 1));
                usr_wdata_in = $urandom;
                if (usr_wren_in) ref_mem[usr_waddr_in] = usr_wdata_in;
                exp_d[i] = ref_mem[usr_raddr_in];
            end else begin
                usr_rden_in = 1'b0;
                usr_wren_in = 1'b0;
            end
        end
        check("burst_release", 64'(rd_a.size()), 64'(n + 1));

        // Reset while a correctable scrub read is in flight.
        repeat (2) @(negedge clk);
        inj_all = 1'b1;
        cmd_k = 2'd1;
        @(negedge clk);
        inj_all = 1'b0;
        n = rd_a.size();
        t = 0;
        while (rd_a.size() <= n && t < 100) begin @(negedge clk); t++; end
        rst = 1'b1;
        wn = wr_a.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_wren", 64'(ram_wren_out), 64'(0));
            check("mid_rst_corr", 64'(corrected_cnt_out), 64'(0));
            check("mid_rst_unc", 64'(uncorrectable_cnt_out), 64'(0));
            check("mid_rst_bad", 64'(last_bad_addr_out), 64'(0));
            check("mid_rst_valid", 64'(usr_rdata_valid_out), 64'(0));
        end
        rst = 1'b0;
        n = rd_a.size();
        t = 0;
        while (rd_a.size() <= n && t < 100) begin @(negedge clk); t++; end
        check("restart_read", 64'(rd_a.size()), 64'(n + 1));
        if (rd_a.size() > n) check("restart_addr", 64'(rd_a[n]), 64'(0));
        check("restart_nowr", 64'(wr_a.size()), 64'(wn));
        check("rst_wr_total", 64'(rst_wr), 64'(0));
        repeat (5) @(negedge clk);
        check("restart_corr", 64'(corrected_cnt_out), 64'(1));
        check("restart_wr_n", 64'(wr_a.size()), 64'(wn + 1));
        if (wr_a.size() > wn) begin
            check("restart_wr_addr", 64'(wr_a[wn]), 64'(0));
            check("restart_wr_data", 64'(wr_d[wn]), 64'(ref_mem[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
